// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Request/acknowledge instruction-memory port used by fetch_stage.
//   imem_req   : fetch request, held high until imem_ack
//   imem_addr  : fetch address, stable while imem_req=1
//   imem_ack   : memory returns imem_rdata this cycle
//   imem_rdata : instruction word, valid when imem_ack=1
// Modports: master (fetch side), slave (memory side).
// -----------------------------------------------------------------------------
interface fetch_stage_if #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 16
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
// drives the instruction-memory port, honours downstream stall and branch/jump
// redirect, and keeps a one-entry skid buffer so no fetched word is lost.
//   clk, rst_n         : clock, asynchronous active-low reset
//   imem (master)      : instruction-memory request/acknowledge port
//   i_stall            : downstream cannot accept; outputs hold
//   i_redirect_valid   : branch/jump taken; flush and refetch
//   i_redirect_pc      : new PC, sampled when i_redirect_valid=1
//   o_adder1_out       : address of delivered instruction + PC_INC
//   o_instr_out        : delivered instruction
//   o_instr_valid      : outputs carry a real instruction (0 = bubble)
//   o_bubble_count     : saturating bubble counter (only with FETCH_PERF_CNT_EN)
// Optional feature macro: FETCH_PERF_CNT_EN
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter int                 ADDR_W   = 16,
   parameter int                 INSTR_W  = 16,
   parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}},
   parameter logic [ADDR_W-1:0]  PC_INC   = {{(ADDR_W-1){1'b0}}, 1'b1}
) (
   input  logic               clk,
   input  logic               rst_n,
   fetch_stage_if.master      imem,
   input  logic               i_stall,
   input  logic               i_redirect_valid,
   input  logic [ADDR_W-1:0]  i_redirect_pc,
   output logic [ADDR_W-1:0]  o_adder1_out,
   output logic [INSTR_W-1:0] o_instr_out,
   output logic               o_instr_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        o_bubble_count
`endif
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_req;
   logic [ADDR_W-1:0]  r_adder1;
   logic [INSTR_W-1:0] r_instr;
   logic               r_valid;
   logic [ADDR_W-1:0]  r_skid_adder1;
   logic [INSTR_W-1:0] r_skid_instr;

   logic               w_ack;
   logic [ADDR_W-1:0]  w_fetch_inc;
   logic [ADDR_W-1:0]  w_pc_next;
   logic [ADDR_W-1:0]  w_addr_next;
   logic               w_req_next;
   logic [ADDR_W-1:0]  w_adder1_next;
   logic [INSTR_W-1:0] w_instr_next;
   logic               w_valid_next;
   logic [ADDR_W-1:0]  w_skid_adder1_next;
   logic [INSTR_W-1:0] w_skid_instr_next;

   // An ack only counts against a request we actually issued.
   assign w_ack       = imem.imem_ack & r_req;
   // Wraps modulo 2^ADDR_W by width truncation.
   assign w_fetch_inc = r_addr + PC_INC;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; redirect overrides everything.
   always_comb begin
      w_next_state = r_state;
      if (i_redirect_valid) begin
         // An un-acked request must be drained before refetching.
         if (r_req && !w_ack) begin
            w_next_state = ST_DRAIN;
         end else begin
            w_next_state = ST_FETCH;
         end
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (w_ack && i_stall) begin
                  w_next_state = ST_HOLD;
               end else begin
                  w_next_state = ST_FETCH;
               end
            end
            ST_HOLD: begin
               if (!i_stall) begin
                  w_next_state = ST_FETCH;
               end else begin
                  w_next_state = ST_HOLD;
               end
            end
            ST_DRAIN: begin
               if (w_ack) begin
                  w_next_state = ST_FETCH;
               end else begin
                  w_next_state = ST_DRAIN;
               end
            end
            default: w_next_state = ST_FETCH;
         endcase
      end
   end

   // Output/datapath logic: next values for PC, outputs, skid and request.
   always_comb begin
      w_pc_next          = r_pc;
      w_adder1_next      = r_adder1;
      w_instr_next       = r_instr;
      w_valid_next       = r_valid;
      w_skid_adder1_next = r_skid_adder1;
      w_skid_instr_next  = r_skid_instr;
      if (i_redirect_valid) begin
         w_pc_next          = i_redirect_pc;
         w_valid_next       = 1'b0;
         w_skid_adder1_next = {ADDR_W{1'b0}};
         w_skid_instr_next  = {INSTR_W{1'b0}};
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (w_ack) begin
                  w_pc_next = r_pc + PC_INC;
                  if (!i_stall) begin
                     w_adder1_next = w_fetch_inc;
                     w_instr_next  = imem.imem_rdata;
                     w_valid_next  = 1'b1;
                  end else begin
                     w_skid_adder1_next = w_fetch_inc;
                     w_skid_instr_next  = imem.imem_rdata;
                  end
               end else if (!i_stall) begin
                  w_valid_next = 1'b0;
               end else begin
                  w_valid_next = r_valid;
               end
            end
            ST_HOLD: begin
               if (!i_stall) begin
                  w_adder1_next      = r_skid_adder1;
                  w_instr_next       = r_skid_instr;
                  w_valid_next       = 1'b1;
                  w_skid_adder1_next = {ADDR_W{1'b0}};
                  w_skid_instr_next  = {INSTR_W{1'b0}};
               end else begin
                  w_valid_next = r_valid;
               end
            end
            ST_DRAIN: begin
               // Returned data belongs to the flushed path and is dropped.
               w_valid_next = 1'b0;
            end
            default: begin
               w_valid_next = 1'b0;
            end
         endcase
      end
      w_req_next = (w_next_state != ST_HOLD);
      // DRAIN keeps the old address on the bus until its ack arrives.
      if (w_next_state == ST_DRAIN) begin
         w_addr_next = r_addr;
      end else begin
         w_addr_next = w_pc_next;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_addr        <= RESET_PC;
         r_req         <= 1'b0;
         r_adder1      <= {ADDR_W{1'b0}};
         r_instr       <= {INSTR_W{1'b0}};
         r_valid       <= 1'b0;
         r_skid_adder1 <= {ADDR_W{1'b0}};
         r_skid_instr  <= {INSTR_W{1'b0}};
      end else begin
         r_pc          <= w_pc_next;
         r_addr        <= w_addr_next;
         r_req         <= w_req_next;
         r_adder1      <= w_adder1_next;
         r_instr       <= w_instr_next;
         r_valid       <= w_valid_next;
         r_skid_adder1 <= w_skid_adder1_next;
         r_skid_instr  <= w_skid_instr_next;
      end
   end

   assign imem.imem_req  = r_req;
   assign imem.imem_addr = r_addr;
   assign o_adder1_out   = r_adder1;
   assign o_instr_out    = r_instr;
   assign o_instr_valid  = r_valid;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_bubble_count;

   // Saturating count of cycles presenting a bubble to a ready consumer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bubble_count <= 32'd0;
      end else if (!r_valid && !i_stall && (r_bubble_count != 32'hFFFF_FFFF)) begin
         r_bubble_count <= r_bubble_count + 32'd1;
      end else begin
         r_bubble_count <= r_bubble_count;
      end
   end

   assign o_bubble_count = r_bubble_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic [15:0] adder1_out;
   logic [15:0] instr_out;
   logic        instr_valid;
   logic        ack_en;
   int          n_chk;
   int          n_err;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] bubble_count;
`endif

   fetch_stage_if #(.ADDR_W(16), .INSTR_W(16)) u_if ();

   // Memory model: acks whenever enabled, data = 0x1000 + address.
   assign u_if.imem_ack   = u_if.imem_req & ack_en;
   assign u_if.imem_rdata = 16'h1000 + u_if.imem_addr;

   fetch_stage u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem             (u_if),
      .i_stall          (stall),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .o_adder1_out     (adder1_out),
      .o_instr_out      (instr_out),
      .o_instr_valid    (instr_valid)
`ifdef FETCH_PERF_CNT_EN
      ,
      .o_bubble_count   (bubble_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000; ack_en = 1'b1;
      tick(); tick();
      n_chk++; if (u_if.imem_req !== 1'b0) begin $display("FAIL reset_req got %h want 0", u_if.imem_req); n_err++; end
      n_chk++; if (instr_valid !== 1'b0) begin $display("FAIL reset_valid got %h want 0", instr_valid); n_err++; end
      n_chk++; if (adder1_out !== 16'h0000) begin $display("FAIL reset_adder1 got %h want 0000", adder1_out); n_err++; end
      n_chk++; if (instr_out !== 16'h0000) begin $display("FAIL reset_instr got %h want 0000", instr_out); n_err++; end
      rst_n = 1'b1;
   endtask

   task automatic test_sequential();
      tick();
      n_chk++; if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
         $display("FAIL first_req got req=%h addr=%h valid=%h want 1 0000 0", u_if.imem_req, u_if.imem_addr, instr_valid); n_err++; end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++; if (instr_valid !== 1'b1 || adder1_out !== 16'(i + 1) || instr_out !== 16'(16'h1000 + i) || u_if.imem_addr !== 16'(i + 1)) begin
            $display("FAIL seq_%0d got v=%h a=%h i=%h addr=%h want 1 %h %h %h", i, instr_valid, adder1_out, instr_out,
                     u_if.imem_addr, 16'(i + 1), 16'(16'h1000 + i), 16'(i + 1)); n_err++; end
      end
   endtask

   task automatic test_ack_delay();
      tick();
      n_chk++; if (instr_out !== 16'h1003 || u_if.imem_addr !== 16'h0004) begin
         $display("FAIL pre_delay got i=%h addr=%h want 1003 0004", instr_out, u_if.imem_addr); n_err++; end
      ack_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++; if (instr_valid !== 1'b0 || u_if.imem_req !== 1'b1 || u_if.imem_addr !== 16'h0004) begin
            $display("FAIL delay_%0d got v=%h req=%h addr=%h want 0 1 0004", i, instr_valid, u_if.imem_req, u_if.imem_addr); n_err++; end
      end
      ack_en = 1'b1;
      tick();
      n_chk++; if (instr_valid !== 1'b1 || instr_out !== 16'h1004 || adder1_out !== 16'h0005 || u_if.imem_addr !== 16'h0005) begin
         $display("FAIL delay_done got v=%h i=%h a=%h addr=%h want 1 1004 0005 0005", instr_valid, instr_out, adder1_out, u_if.imem_addr); n_err++; end
   endtask

   task automatic test_stall();
      tick(); tick();
      n_chk++; if (instr_out !== 16'h1006 || u_if.imem_addr !== 16'h0007) begin
         $display("FAIL pre_stall got i=%h addr=%h want 1006 0007", instr_out, u_if.imem_addr); n_err++; end
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_chk++; if (u_if.imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_out !== 16'h1006 || adder1_out !== 16'h0007) begin
            $display("FAIL stall_%0d got req=%h v=%h i=%h a=%h want 0 1 1006 0007", i, u_if.imem_req, instr_valid, instr_out, adder1_out); n_err++; end
      end
      stall = 1'b0;
      tick();
      n_chk++; if (instr_valid !== 1'b1 || instr_out !== 16'h1007 || adder1_out !== 16'h0008 || u_if.imem_req !== 1'b1 || u_if.imem_addr !== 16'h0008) begin
         $display("FAIL unstall got v=%h i=%h a=%h req=%h addr=%h want 1 1007 0008 1 0008", instr_valid, instr_out, adder1_out,
                  u_if.imem_req, u_if.imem_addr); n_err++; end
      tick();
      n_chk++; if (instr_out !== 16'h1008 || adder1_out !== 16'h0009 || u_if.imem_addr !== 16'h0009) begin
         $display("FAIL after_unstall got i=%h a=%h addr=%h want 1008 0009 0009", instr_out, adder1_out, u_if.imem_addr); n_err++; end
   endtask

   task automatic test_redirect();
      ack_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0040;
      tick();
      n_chk++; if (instr_valid !== 1'b0 || u_if.imem_req !== 1'b1 || u_if.imem_addr !== 16'h0009) begin
         $display("FAIL drain_hold got v=%h req=%h addr=%h want 0 1 0009", instr_valid, u_if.imem_req, u_if.imem_addr); n_err++; end
      redirect_valid = 1'b0; ack_en = 1'b1;
      tick();
      n_chk++; if (instr_valid !== 1'b0 || u_if.imem_addr !== 16'h0040) begin
         $display("FAIL drain_discard got v=%h addr=%h want 0 0040", instr_valid, u_if.imem_addr); n_err++; end
      tick();
      n_chk++; if (instr_valid !== 1'b1 || instr_out !== 16'h1040 || adder1_out !== 16'h0041) begin
         $display("FAIL redirect_data got v=%h i=%h a=%h want 1 1040 0041", instr_valid, instr_out, adder1_out); n_err++; end
   endtask

   task automatic test_redirect_stall();
      stall = 1'b1;
      tick();
      n_chk++; if (u_if.imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_out !== 16'h1040) begin
         $display("FAIL skid_fill got req=%h v=%h i=%h want 0 1 1040", u_if.imem_req, instr_valid, instr_out); n_err++; end
      redirect_valid = 1'b1; redirect_pc = 16'h0080;
      tick();
      n_chk++; if (instr_valid !== 1'b0 || u_if.imem_req !== 1'b1 || u_if.imem_addr !== 16'h0080) begin
         $display("FAIL flush_stall got v=%h req=%h addr=%h want 0 1 0080", instr_valid, u_if.imem_req, u_if.imem_addr); n_err++; end
      redirect_valid = 1'b0; stall = 1'b0;
      tick();
      n_chk++; if (instr_valid !== 1'b1 || instr_out !== 16'h1080 || adder1_out !== 16'h0081) begin
         $display("FAIL flush_resume got v=%h i=%h a=%h want 1 1080 0081", instr_valid, instr_out, adder1_out); n_err++; end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
      tick();
      n_chk++; if (instr_valid !== 1'b0 || u_if.imem_addr !== 16'hFFFF) begin
         $display("FAIL wrap_redirect got v=%h addr=%h want 0 ffff", instr_valid, u_if.imem_addr); n_err++; end
      redirect_valid = 1'b0;
      tick();
      n_chk++; if (instr_valid !== 1'b1 || adder1_out !== 16'h0000 || instr_out !== 16'h0FFF || u_if.imem_addr !== 16'h0000) begin
         $display("FAIL wrap got v=%h a=%h i=%h addr=%h want 1 0000 0fff 0000", instr_valid, adder1_out, instr_out, u_if.imem_addr); n_err++; end
      tick();
      n_chk++; if (adder1_out !== 16'h0001 || instr_out !== 16'h1000) begin
         $display("FAIL post_wrap got a=%h i=%h want 0001 1000", adder1_out, instr_out); n_err++; end
   endtask

`ifdef FETCH_PERF_CNT_EN
   task automatic test_perf();
      rst_n = 1'b0; ack_en = 1'b0; stall = 1'b0;
      tick();
      n_chk++; if (bubble_count !== 32'd0) begin $display("FAIL perf_reset got %0d want 0", bubble_count); n_err++; end
      rst_n = 1'b1;
      tick(); tick(); tick();
      n_chk++; if (bubble_count !== 32'd3) begin $display("FAIL perf_count got %0d want 3", bubble_count); n_err++; end
      stall = 1'b1;
      tick();
      n_chk++; if (bubble_count !== 32'd3) begin $display("FAIL perf_stall got %0d want 3", bubble_count); n_err++; end
      stall = 1'b0;
   endtask
`endif

   initial begin
      n_chk = 0;
      n_err = 0;
      test_reset();
      test_sequential();
      test_ack_delay();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_wrap();
`ifdef FETCH_PERF_CNT_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
